// File: rtl/ctrl_pkg.sv
// Shared control-word bit positions, step limit and sequencer state encoding
// for the control sequencer and the microcode ROM.
package ctrl_pkg;

  localparam int CW_STEP_END = 15;
  localparam int CW_PC_JMP   = 14;
  localparam int CW_PC_OUT   = 13;
  localparam int CW_PC_COUNT = 12;
  localparam int CW_DISP_EN  = 11;
  localparam int CW_B_WR     = 10;
  localparam int CW_ALU_SU   = 9;
  localparam int CW_ALU_EN   = 8;
  localparam int CW_A_EN     = 7;
  localparam int CW_A_WR     = 6;
  localparam int CW_IR_EN    = 5;
  localparam int CW_IR_WR    = 4;
  localparam int CW_RAM_EN   = 3;
  localparam int CW_RAM_WR   = 2;
  localparam int CW_MAR_WR   = 1;
  localparam int CW_HLT      = 0;

  // Last legal microstep; anything above it is treated as corrupted state.
  localparam logic [2:0] STEP_LAST = 3'd4;

  typedef enum logic {
    SEQ_EXEC   = 1'b0,
    SEQ_HALTED = 1'b1
  } seq_state_t;

endpackage

// File: rtl/control_sequencer_flags_reg.sv
// Carry/zero flag register with a single load enable; feeds the ROM's
// conditional-jump inputs.
module flags_reg (
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  logic c_in,
  input  logic z_in,
  output logic c,
  output logic z
);

  always_ff @(posedge clk) begin
    if (rst) begin
      c <= 1'b0;
      z <= 1'b0;
    end else if (ld) begin
      c <= c_in;
      z <= z_in;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Control-unit core: microstep counter, halt/resume FSM, control-word gating,
// flag register and retired-instruction counter.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   SEQ_EXEC   | stepping microcode; advances on run or step_pulse
//   SEQ_HALTED | after an HLT word; everything frozen until resume
module control_sequencer
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step_pulse,
  input  logic        resume,
  input  logic [15:0] ctrl_word_in,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic [2:0]  step,
  output logic [15:0] ctrl_out,
  output logic        carry_flag,
  output logic        zero_flag,
  output logic        halted,
  output logic [15:0] retired
);

  seq_state_t  state;
  logic [2:0]  step_q;
  logic [15:0] retired_q;

  logic       adv;
  logic       step_bad;
  logic       step_wrap;
  logic [2:0] step_next;
  logic       hlt_req;
  logic       retire_inc;

  always_comb begin
    adv        = (run | step_pulse) & (state == SEQ_EXEC);
    step_bad   = step_q > STEP_LAST;
    step_wrap  = ctrl_word_in[CW_STEP_END] | (step_q >= STEP_LAST);
    step_next  = step_wrap ? 3'd0 : step_q + 3'd1;
    hlt_req    = adv & ctrl_word_in[CW_HLT];
    // A halt always retires, even when it lands before step 2.
    retire_inc = hlt_req | (adv & step_wrap & (step_q >= 3'd2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEQ_EXEC;
      step_q    <= 3'd0;
      retired_q <= 16'h0000;
    end else begin
      case (state)
        SEQ_EXEC: begin
          if (hlt_req) begin
            state  <= SEQ_HALTED;
            step_q <= 3'd0;
          end else if (adv) begin
            step_q <= step_next;
          end else if (step_bad) begin
            step_q <= 3'd0;
          end
          if (retire_inc) retired_q <= retired_q + 16'd1;
        end
        SEQ_HALTED: begin
          if (resume) state <= SEQ_EXEC;
          if (resume || step_bad) step_q <= 3'd0;
        end
        default: begin
          state  <= SEQ_EXEC;
          step_q <= 3'd0;
        end
      endcase
    end
  end

  flags_reg u_flags (
    .clk  (clk),
    .rst  (rst),
    .ld   (adv & ctrl_word_in[CW_ALU_EN]),
    .c_in (alu_carry),
    .z_in (alu_zero),
    .c    (carry_flag),
    .z    (zero_flag)
  );

  assign ctrl_out = adv ? ctrl_word_in : 16'h0000;
  assign step     = step_q;
  assign retired  = retired_q;
  assign halted   = (state == SEQ_HALTED);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer with a small microcode ROM model
// driving ctrl_word_in from the live step and flags.
module tb_control_sequencer;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_JC  = 3'd3;
  localparam logic [2:0] OP_HLT = 3'd4;

  logic        clk = 1'b0;
  logic        rst, run, step_pulse, resume, alu_carry, alu_zero;
  logic [15:0] ctrl_word_in;
  logic [2:0]  step;
  logic [15:0] ctrl_out, retired;
  logic        carry_flag, zero_flag, halted;

  logic [2:0]  ir;
  logic [15:0] ctrl_pre;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pre_force = 0;

  logic [2:0]  m_step = 3'd0;
  logic        m_c = 1'b0, m_z = 1'b0, m_h = 1'b0;
  logic [15:0] m_ret = 16'h0000;

  typedef struct {
    string       tag;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        c;
    logic        z;
    logic        h;
    logic [15:0] ret;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .step_pulse   (step_pulse),
    .resume       (resume),
    .ctrl_word_in (ctrl_word_in),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .step         (step),
    .ctrl_out     (ctrl_out),
    .carry_flag   (carry_flag),
    .zero_flag    (zero_flag),
    .halted       (halted),
    .retired      (retired)
  );

  function automatic logic [15:0] rom(input logic [2:0] op, input logic [2:0] s,
                                      input logic c, input logic z);
    logic [15:0] w;
    w = 16'h0000;
    if (s == 3'd0) w = 16'h2002;
    else if (s == 3'd1) w = 16'h1018;
    else begin
      case (op)
        OP_NOP: if (s == 3'd2) w = 16'h8000;
        OP_LDA: if (s == 3'd2) w = 16'h0022; else if (s == 3'd3) w = 16'h8048;
        OP_ADD: if (s == 3'd2) w = 16'h0022; else if (s == 3'd3) w = 16'h0408;
                else if (s == 3'd4) w = 16'h8140;
        OP_JC:  if (s == 3'd2) w = c ? 16'hC020 : 16'h8000;
        OP_HLT: if (s == 3'd2) w = 16'h8001;
        default: w = 16'h0000;
      endcase
    end
    if (z && op == 3'd7) w = 16'h0000;
    return w;
  endfunction

  always_comb ctrl_word_in = rom(ir, step, carry_flag, zero_flag);

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: ctrl_out sampled just before the edge, registers just after.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk); #2;
      ctrl_pre = ctrl_out;
      @(posedge clk); #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq({e.tag, ".ctrl_out"}, ctrl_pre, e.ctrl);
        check_eq({e.tag, ".step"}, {13'd0, step}, {13'd0, e.step});
        check_eq({e.tag, ".carry"}, {15'd0, carry_flag}, {15'd0, e.c});
        check_eq({e.tag, ".zero"}, {15'd0, zero_flag}, {15'd0, e.z});
        check_eq({e.tag, ".halted"}, {15'd0, halted}, {15'd0, e.h});
        check_eq({e.tag, ".retired"}, retired, e.ret);
      end
    end
  end

  task automatic tick(input logic t_run, input logic t_pulse, input logic t_resume,
                      input logic t_rst, input logic t_c, input logic t_z, input string t_tag);
    sb_t         e;
    logic [15:0] w;
    logic        a, wrap;
    @(negedge clk);
    if (pre_force == 1) begin
      force dut.step_q = 3'd5; #1; release dut.step_q; m_step = 3'd5;
    end else if (pre_force == 2) begin
      force dut.retired_q = 16'hFFFF; #1; release dut.retired_q; m_ret = 16'hFFFF;
    end
    pre_force = 0;
    run = t_run; step_pulse = t_pulse; resume = t_resume; rst = t_rst;
    alu_carry = t_c; alu_zero = t_z;
    #1;
    w = rom(ir, m_step, m_c, m_z);
    a = (t_run | t_pulse) & ~m_h;
    e.ctrl = a ? w : 16'h0000;
    if (t_rst) begin
      m_step = 3'd0; m_c = 1'b0; m_z = 1'b0; m_h = 1'b0; m_ret = 16'h0000;
    end else if (m_h) begin
      if (t_resume || m_step > 3'd4) m_step = 3'd0;
      if (t_resume) m_h = 1'b0;
    end else if (a) begin
      wrap = w[15] || (m_step >= 3'd4);
      if (w[8]) begin m_c = t_c; m_z = t_z; end
      if (w[0]) begin
        m_h = 1'b1; m_ret = m_ret + 16'd1; m_step = 3'd0;
      end else begin
        if (wrap && m_step >= 3'd2) m_ret = m_ret + 16'd1;
        m_step = wrap ? 3'd0 : m_step + 3'd1;
      end
    end else if (m_step > 3'd4) begin
      m_step = 3'd0;
    end
    e.tag = t_tag; e.step = m_step; e.c = m_c; e.z = m_z; e.h = m_h; e.ret = m_ret;
    sb_q.push_back(e);
    @(posedge clk); #2;
  endtask

  task automatic run_instr(input logic [2:0] op, input int cycles, input logic c,
                           input logic z, input string tag);
    ir = op;
    for (int i = 0; i < cycles; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, c, z, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; step_pulse = 1'b0; resume = 1'b0;
    alu_carry = 1'b0; alu_zero = 1'b0; ir = OP_NOP;

    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "reset");
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "reset");
    check_eq("reset_step", {13'd0, step}, 16'd0);

    run_instr(OP_NOP, 3, 1'b0, 1'b0, "nop");
    check_eq("nop_retired", retired, 16'd1);
    run_instr(OP_LDA, 4, 1'b0, 1'b0, "lda");
    check_eq("lda_retired", retired, 16'd2);
    run_instr(OP_ADD, 5, 1'b1, 1'b0, "add");
    check_eq("add_retired", retired, 16'd3);
    check_eq("add_carry", {15'd0, carry_flag}, 16'd1);
    check_eq("add_zero", {15'd0, zero_flag}, 16'd0);
    run_instr(OP_JC, 3, 1'b0, 1'b0, "jc");
    check_eq("jc_pc_jmp", ctrl_pre, 16'hC020);

    run_instr(OP_HLT, 3, 1'b0, 1'b0, "hlt");
    check_eq("hlt_word", ctrl_pre, 16'h8001);
    check_eq("hlt_halted", {15'd0, halted}, 16'd1);
    for (int i = 0; i < 10; i++) tick(1'b1, i[0], 1'b0, 1'b0, 1'b1, 1'b1, "halted");
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "resume");
    check_eq("resume_halted", {15'd0, halted}, 16'd0);
    run_instr(OP_NOP, 3, 1'b0, 1'b0, "post_resume");

    ir = OP_LDA;
    for (int p = 0; p < 3; p++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "pulse");
      check_eq("pulse_step", {13'd0, step}, 16'(p + 1));
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap");
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "pulse_end");

    run_instr(OP_ADD, 3, 1'b0, 1'b1, "add_part");
    check_eq("rst_pre_carry", {15'd0, carry_flag}, 16'd1);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "mid_rst");
    check_eq("mid_rst_retired", retired, 16'd0);

    pre_force = 2;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "preload");
    run_instr(OP_NOP, 3, 1'b0, 1'b0, "wrap");
    check_eq("retired_wrap", retired, 16'h0000);

    pre_force = 1;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "bad_step");
    check_eq("bad_step_cleared", {13'd0, step}, 16'd0);

    for (int i = 0; i < 400; i++) begin
      if (m_step == 3'd0 && $urandom_range(0, 1) == 1) ir = 3'($urandom_range(0, 4));
      tick($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 63) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
